// File: rtl/vendor_pkg.sv
// Shared types and pricing for the ticket vending controller.
package vendor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_TICKET,
    ST_CHANGE
  } state_t;

  localparam int unsigned PRICE_W = 2;
  localparam int unsigned ONE_VAL = 1;
  localparam int unsigned TEN_VAL = 10;

  // Near half of the line costs 1 unit, far half costs 2.
  function automatic logic [PRICE_W-1:0] price(input logic [31:0] dest,
                                               input int unsigned stations);
    return (dest < 32'(stations / 2)) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/vendor_rise_detect.sv
// Registered rising-edge detector: pulse_c is high for the first cycle a level is seen high.
module rise_detect (
  input  logic level,
  output logic pulse_c,
  input  logic clk,
  input  logic rst_n
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse_c = level & ~prev;

endmodule

// File: rtl/vendor.sv
// Ticket vending controller: accumulates coin credit, then dispenses tickets
// and one-unit change (or refunds) as 1-high/1-low pulse trains.
module vendor
  import vendor_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STATIONS = 16
) (
  output logic             ticket,
  output logic             one_output,
  input  logic [WIDTH-1:0] dest,
  input  logic [WIDTH-1:0] count,
  input  logic             one_insert,
  input  logic             ten_insert,
  input  logic             done,
  input  logic             clk,
  input  logic             rst_n
);

  localparam int unsigned TOT_W = WIDTH + 2;
  localparam int unsigned SUM_W = WIDTH + 4;
  localparam logic [SUM_W-1:0] CREDIT_MAX = {4'b0000, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] DEC = WIDTH'(1);

  logic one_evt_c;
  logic ten_evt_c;
  logic done_evt_c;

  rise_detect u_one  (.level(one_insert), .pulse_c(one_evt_c),  .clk(clk), .rst_n(rst_n));
  rise_detect u_ten  (.level(ten_insert), .pulse_c(ten_evt_c),  .clk(clk), .rst_n(rst_n));
  rise_detect u_done (.level(done),       .pulse_c(done_evt_c), .clk(clk), .rst_n(rst_n));

  state_t           state;
  logic [WIDTH-1:0] credit;
  logic [WIDTH-1:0] dest_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] tickets_left;
  logic [WIDTH-1:0] change_left;

  // Saturating credit accumulation; the sum is formed wide enough that +11 never wraps.
  logic [SUM_W-1:0] coin_add_c;
  logic [SUM_W-1:0] credit_sum_c;
  logic [WIDTH-1:0] credit_next_c;

  assign coin_add_c    = (one_evt_c ? SUM_W'(ONE_VAL) : '0) + (ten_evt_c ? SUM_W'(TEN_VAL) : '0);
  assign credit_sum_c  = SUM_W'(credit) + coin_add_c;
  assign credit_next_c = (credit_sum_c > CREDIT_MAX) ? CREDIT_MAX[WIDTH-1:0]
                                                     : credit_sum_c[WIDTH-1:0];

  logic [TOT_W-1:0] total_c;
  logic             valid_c;
  logic             sale_c;

  assign total_c = TOT_W'(count_q) * TOT_W'(price(32'(dest_q), STATIONS));
  assign valid_c = 32'(dest_q) < STATIONS;
  assign sale_c  = valid_c && (total_c != '0) && (TOT_W'(credit) >= total_c);

  // The pulse outputs double as phase bits; the *_left counters hold pulses still
  // owed after the one currently being issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      credit       <= '0;
      dest_q       <= '0;
      count_q      <= '0;
      tickets_left <= '0;
      change_left  <= '0;
      ticket       <= 1'b0;
      one_output   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          credit <= credit_next_c;
          if (done_evt_c) begin
            dest_q  <= dest;
            count_q <= count;
            state   <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          credit <= '0;
          if (sale_c) begin
            ticket       <= 1'b1;
            tickets_left <= count_q - DEC;
            change_left  <= credit - WIDTH'(total_c);
            state        <= ST_TICKET;
          end else begin
            tickets_left <= '0;
            if (credit != '0) begin
              one_output  <= 1'b1;
              change_left <= credit - DEC;
              state       <= ST_CHANGE;
            end else begin
              change_left <= '0;
              state       <= ST_IDLE;
            end
          end
        end
        ST_TICKET: begin
          if (ticket) begin
            ticket <= 1'b0;
          end else if (tickets_left != '0) begin
            ticket       <= 1'b1;
            tickets_left <= tickets_left - DEC;
          end else if (change_left != '0) begin
            one_output  <= 1'b1;
            change_left <= change_left - DEC;
            state       <= ST_CHANGE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CHANGE: begin
          if (one_output) begin
            one_output <= 1'b0;
          end else if (change_left != '0) begin
            one_output  <= 1'b1;
            change_left <= change_left - DEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vendor.sv
// Self-checking bench for vendor: directed vector table, corner sequences and random purchases.
module tb_vendor;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned STATIONS = 16;
  localparam int          CREDIT_MAX = 255;

  logic             clk;
  logic             rst_n;
  logic             ticket;
  logic             one_output;
  logic [WIDTH-1:0] dest;
  logic [WIDTH-1:0] count;
  logic             one_insert;
  logic             ten_insert;
  logic             done;

  int checks = 0;
  int errors = 0;
  int model_credit = 0;

  vendor #(.WIDTH(WIDTH), .STATIONS(STATIONS)) dut (
    .ticket    (ticket),
    .one_output(one_output),
    .dest      (dest),
    .count     (count),
    .one_insert(one_insert),
    .ten_insert(ten_insert),
    .done      (done),
    .clk       (clk),
    .rst_n     (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dest;
    int count;
    int ones;
    int tens;
    int hold;
    int exp_t;
    int exp_c;
  } vec_t;

  vec_t vecs[8];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference purchase outcome from the pricing rules.
  function automatic void model_done(input int d, input int c, output int t, output int ch);
    int total;
    bit sale;
    total = c * ((d < STATIONS / 2) ? 1 : 2);
    sale  = (d < STATIONS) && (total > 0) && (model_credit >= total);
    t     = sale ? c : 0;
    ch    = sale ? model_credit - total : model_credit;
  endfunction

  task automatic coin(input bit o, input bit t);
    one_insert = o;
    ten_insert = t;
    @(negedge clk);
    one_insert = 1'b0;
    ten_insert = 1'b0;
    @(negedge clk);
    model_credit = model_credit + (o ? 1 : 0) + (t ? 10 : 0);
    if (model_credit > CREDIT_MAX) model_credit = CREDIT_MAX;
  endtask

  // Raises done and checks every cycle of the expected ticket/change pulse trains.
  task automatic purchase(input int d, input int c, input int hold, input int coin_at,
                          input int exp_t, input int exp_c, input string name);
    int n;
    int nt;
    int no;
    logic et;
    logic eo;
    n  = 1 + 2 * exp_t + 2 * exp_c;
    nt = 0;
    no = 0;
    dest  = WIDTH'(d);
    count = WIDTH'(c);
    done  = 1'b1;
    for (int j = 1; j <= n + 2; j++) begin
      @(negedge clk);
      if (j == hold) done = 1'b0;
      ten_insert = (j == coin_at);
      et = (j >= 2) && (j <= 2 * exp_t + 1) && (j % 2 == 0);
      eo = (j >= 2 * exp_t + 2) && (j <= 2 * exp_t + 2 * exp_c + 1) && (j % 2 == 0);
      nt += int'(ticket);
      no += int'(one_output);
      checks++;
      if (ticket !== et || one_output !== eo) begin
        errors++;
        $display("FAIL %s cycle %0d: ticket=%b one_output=%b expected ticket=%b one_output=%b",
                 name, j, ticket, one_output, et, eo);
      end
    end
    done       = 1'b0;
    ten_insert = 1'b0;
    check_int({name, " tickets"}, nt, exp_t);
    check_int({name, " change"}, no, exp_c);
    model_credit = 0;
  endtask

  initial begin
    int et;
    int ec;
    int d;
    int c;
    int nc;
    bit o;
    bit t;

    vecs[0] = '{dest: 15, count: 3, ones: 2, tens: 1, hold: 2, exp_t: 3, exp_c: 6};
    vecs[1] = '{dest: 3,  count: 5, ones: 3, tens: 0, hold: 1, exp_t: 0, exp_c: 3};
    vecs[2] = '{dest: 20, count: 1, ones: 0, tens: 1, hold: 1, exp_t: 0, exp_c: 10};
    vecs[3] = '{dest: 0,  count: 0, ones: 4, tens: 0, hold: 3, exp_t: 0, exp_c: 4};
    vecs[4] = '{dest: 7,  count: 4, ones: 4, tens: 0, hold: 1, exp_t: 4, exp_c: 0};
    vecs[5] = '{dest: 8,  count: 2, ones: 1, tens: 1, hold: 1, exp_t: 2, exp_c: 7};
    vecs[6] = '{dest: 16, count: 1, ones: 0, tens: 0, hold: 1, exp_t: 0, exp_c: 0};
    vecs[7] = '{dest: 5,  count: 2, ones: 0, tens: 0, hold: 2, exp_t: 0, exp_c: 0};

    rst_n      = 1'b0;
    dest       = WIDTH'(16);
    count      = '0;
    one_insert = 1'b0;
    ten_insert = 1'b0;
    done       = 1'b0;
    repeat (2) @(negedge clk);
    check_bit("reset ticket", ticket, 1'b0);
    check_bit("reset one_output", one_output, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_bit("idle ticket", ticket, 1'b0);
      check_bit("idle one_output", one_output, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < vecs[i].ones; k++) coin(1'b1, 1'b0);
      for (int k = 0; k < vecs[i].tens; k++) coin(1'b0, 1'b1);
      purchase(vecs[i].dest, vecs[i].count, vecs[i].hold, 0,
               vecs[i].exp_t, vecs[i].exp_c, $sformatf("vec%0d", i));
    end

    // A held coin level counts once.
    one_insert = 1'b1;
    repeat (5) @(negedge clk);
    one_insert = 1'b0;
    @(negedge clk);
    purchase(0, 1, 1, 0, 1, 0, "held_coin");

    coin(1'b1, 1'b1);
    purchase(20, 1, 1, 0, 0, 11, "both_coins");

    repeat (26) coin(1'b0, 1'b1);
    purchase(15, 100, 1, 0, 100, 55, "saturate");

    // A coin arriving mid-dispense must be ignored; credit afterwards is zero.
    coin(1'b1, 1'b0);
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    purchase(15, 3, 1, 3, 3, 6, "coin_in_ticket");
    coin(1'b1, 1'b0);
    purchase(0, 1, 1, 0, 1, 0, "after_ignored_coin");

    // Reset during change return aborts at once.
    coin(1'b0, 1'b1);
    dest  = WIDTH'(20);
    count = WIDTH'(1);
    done  = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) done = 1'b0;
    end
    check_bit("pre_reset one_output", one_output, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("abort ticket", ticket, 1'b0);
    check_bit("abort one_output", one_output, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_credit = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("post_abort one_output", one_output, 1'b0);
    end
    coin(1'b1, 1'b0);
    purchase(0, 1, 1, 0, 1, 0, "after_abort");

    for (int r = 0; r < 20; r++) begin
      nc = $urandom_range(0, 6);
      for (int k = 0; k < nc; k++) begin
        o = 1'($urandom_range(0, 1));
        t = 1'($urandom_range(0, 1));
        if (o || t) coin(o, t);
      end
      d = $urandom_range(0, 23);
      c = $urandom_range(0, 12);
      model_done(d, c, et, ec);
      purchase(d, c, $urandom_range(1, 3), 0, et, ec, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
